seg7_scan_dec: RTL and testbench
================================

SEG7_SCAN_DEC -- requirements
Module: seg7_scan_dec

Interface
REQ-001 SHALL have parameter STABLE_CYC, default 4, range 1..255: consecutive identical samples required before a pattern is accepted.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port in_en, input, 1, sample qualifier; seg_n/sel are ignored when low.
REQ-005 SHALL have port seg_n, input, 8, active-low segment bus; bit7..bit1 = a..g, bit0 = dp.
REQ-006 SHALL have port sel, input, 3, index of the digit currently driven on seg_n.
REQ-007 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the result handshake.
REQ-008 SHALL have ports out_digit (output, 4), out_idx (output, 3), out_dp (output, 1), out_err (output, 1) and out_blank (output, 1), the result fields.
REQ-009 SHALL have port digits, output, 32, decoded value store; digit i at bits [4i+3:4i].
REQ-010 SHALL have port err_mask, output, 8; bit i is set when digit i last decoded as invalid.
REQ-011 SHALL have port overrun, output, 1, sticky flag for a dropped result.

Function
REQ-012 SHALL decode p = ~seg_n[7:1] (a..g, active-high) with this table: 7E=0, 30=1, 6D=2, 79=3, 33=4, 5B=5, 5F=6, 70=7, 7F=8, 7B=9, 77=A, 1F=b, 4E=C, 3C=d, 4F=E, 47=F.
REQ-013 SHALL treat p = 00 as blank (out_blank=1, out_err=0, out_digit=0).
REQ-014 SHALL treat any other p as invalid (out_err=1, out_digit=0).
REQ-015 SHALL report out_dp = ~seg_n[0]; bit0 SHALL NOT take part in matching.
REQ-016 SHALL implement three states. IDLE: in_en=0. TRACK: counting stable samples. LOCK: pattern reported, waiting for a change.
REQ-017 SHALL go to IDLE, clear the counter and mark the previous-sample register invalid on any edge with in_en=0.
REQ-018 SHALL handle a change: with in_en=1 and {seg_n,sel} differing from the stored sample (or stored sample invalid), store the sample, set cnt=1 and enter TRACK.
REQ-019 SHALL handle an unchanged sample in TRACK by setting cnt=cnt+1.
REQ-020 SHALL, on the edge where cnt reaches STABLE_CYC, decode, update the store and emit a result, then enter LOCK; with STABLE_CYC=1 this happens on the change edge itself.
REQ-021 SHALL emit nothing further in LOCK while the input is unchanged; a change SHALL re-enter TRACK per REQ-018.
REQ-022 SHALL, on result emission, write digits[sel] when the decode is valid and non-blank, set err_mask[sel] on invalid, and clear err_mask[sel] otherwise.
REQ-023 SHALL keep the result fields stable while out_valid is high until the edge with out_valid && out_ready.
REQ-024 SHALL load a new result on the same edge that consumes the held one (new result plus handshake), with overrun unchanged.
REQ-025 SHALL, when a new result arrives while out_valid=1 and out_ready=0, drop it from the output, still update the store per REQ-022, and set overrun=1.
REQ-026 SHALL saturate cnt at STABLE_CYC using an 8-bit width, with no wrap-around.

Reset
REQ-027 SHALL, on rst=1 at an edge, enter IDLE, clear cnt, the stored-sample valid flag, out_valid, out_digit, out_idx, out_dp, out_err, out_blank, digits, err_mask and overrun to 0.
REQ-028 SHALL give rst priority over all other inputs and SHALL discard any in-flight TRACK count or held result.

Structure
REQ-029 SHALL place the 16-entry a..g pattern table and the state encoding in package seg7_pkg, shared by all 7-segment blocks.
REQ-030 SHALL contain one combinational sub-module, seg7_match (p -> nibble, err, blank), instantiated once.

Verification
REQ-031 SHALL cover: STABLE_CYC=4, sel=2, seg_n=8'h0D held 4 edges, out_ready=1 -> out_valid one cycle after the 4th sample; out_digit=3, out_idx=2, digits[11:8]=3.
REQ-032 SHALL cover: seg_n=8'h0D for 3 edges, then 8'h1F for 4 edges -> no result for 3; a single result of 7.
REQ-033 SHALL cover: seg_n=8'h7F stable on sel=5 -> out_err=1, err_mask=8'h20, digits unchanged; then a valid '1' on sel=5 -> err_mask=0.
REQ-034 SHALL cover: seg_n=8'hFF -> out_blank=1, digits unchanged; a held pattern for 20 edges -> exactly one result.
REQ-035 SHALL cover: out_ready=0 with two stable patterns in sequence -> first result held, overrun=1, digits reflect both patterns.
REQ-036 SHALL cover: rst asserted mid-TRACK and while out_valid=1 -> all outputs 0 next cycle; a restarted pattern needs a full STABLE_CYC samples.

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared 7-segment pattern table, scan FSM encoding and result record
package seg7_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_LOCK  = 2'd2;

  // Active-high a..g patterns (a = bit6), indexed by the hex value they display
  localparam logic [6:0] SEG7_PAT [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3C, 7'h4F, 7'h47
  };

  typedef struct packed {
    logic [3:0] digit;
    logic [2:0] idx;
    logic       dp;
    logic       err;
    logic       blank;
  } seg7_result_t;

endpackage

// File: rtl/seg7_match.sv
// rtl/seg7_match.sv - combinational a..g pattern to nibble decoder with blank/invalid flags
module seg7_match
  import seg7_pkg::*;
(
  input  logic [6:0] i_pat,
  output logic [3:0] o_nibble,
  output logic       o_err,
  output logic       o_blank
);

  always_comb begin
    o_nibble = 4'd0;
    o_err    = 1'b1;
    o_blank  = 1'b0;
    if (i_pat == 7'h00) begin
      o_err   = 1'b0;
      o_blank = 1'b1;
    end else begin
      for (int k = 0; k < 16; k++) begin
        if (SEG7_PAT[k] == i_pat) begin
          o_nibble = 4'(k);
          o_err    = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/seg7_scan_dec.sv
// rtl/seg7_scan_dec.sv - debounced decoder for a scanned 7-segment display bus
module seg7_scan_dec
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYC = 4
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_en,
  input  logic [7:0]  seg_n,
  input  logic [2:0]  sel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_digit,
  output logic [2:0]  out_idx,
  output logic        out_dp,
  output logic        out_err,
  output logic        out_blank,
  output logic [31:0] digits,
  output logic [7:0]  err_mask,
  output logic        overrun
);

  localparam logic [7:0] STABLE_W = 8'(STABLE_CYC);

  logic [1:0]   r_state;
  logic [10:0]  r_prev;
  logic         r_prev_vld;
  logic [7:0]   r_cnt;
  seg7_result_t r_res;
  logic         r_valid;
  logic [31:0]  r_digits;
  logic [7:0]   r_err_mask;
  logic         r_ovr;

  logic [10:0]  w_sample;
  logic         w_change;
  logic         w_emit;
  logic [3:0]   w_nibble;
  logic         w_err;
  logic         w_blank;
  seg7_result_t w_res;

  seg7_match u_match (
    .i_pat    (~seg_n[7:1]),
    .o_nibble (w_nibble),
    .o_err    (w_err),
    .o_blank  (w_blank)
  );

  assign w_sample = {seg_n, sel};
  assign w_change = in_en && (!r_prev_vld || (w_sample != r_prev));

  // On an emitting edge the live inputs equal the tracked sample, so decode them directly
  assign w_emit = (w_change && (STABLE_W == 8'd1)) ||
                  (in_en && !w_change && (r_state == ST_TRACK) && (r_cnt == STABLE_W - 8'd1));

  always_comb begin
    w_res       = '0;
    w_res.digit = w_nibble;
    w_res.idx   = sel;
    w_res.dp    = ~seg_n[0];
    w_res.err   = w_err;
    w_res.blank = w_blank;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_prev     <= '0;
      r_prev_vld <= 1'b0;
      r_cnt      <= 8'd0;
    end else if (!in_en) begin
      r_state    <= ST_IDLE;
      r_prev_vld <= 1'b0;
      r_cnt      <= 8'd0;
    end else if (w_change) begin
      r_prev     <= w_sample;
      r_prev_vld <= 1'b1;
      r_cnt      <= 8'd1;
      r_state    <= w_emit ? ST_LOCK : ST_TRACK;
    end else if (r_state == ST_TRACK) begin
      if (r_cnt < STABLE_W) r_cnt <= r_cnt + 8'd1;
      if (w_emit) r_state <= ST_LOCK;
    end
  end

  // A result that cannot be presented is still recorded in the store, and flagged as overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      r_res      <= '0;
      r_valid    <= 1'b0;
      r_digits   <= '0;
      r_err_mask <= '0;
      r_ovr      <= 1'b0;
    end else if (w_emit) begin
      if (!r_valid || out_ready) begin
        r_res   <= w_res;
        r_valid <= 1'b1;
      end else begin
        r_ovr <= 1'b1;
      end
      if (!w_err && !w_blank) r_digits[{sel, 2'b00} +: 4] <= w_nibble;
      r_err_mask[sel] <= w_err;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_digit = r_res.digit;
  assign out_idx   = r_res.idx;
  assign out_dp    = r_res.dp;
  assign out_err   = r_res.err;
  assign out_blank = r_res.blank;
  assign digits    = r_digits;
  assign err_mask  = r_err_mask;
  assign overrun   = r_ovr;

endmodule

// File: tb/tb_seg7_scan_dec.sv
// tb/tb_seg7_scan_dec.sv - randomized and directed bench for seg7_scan_dec against a run-length model
module tb_seg7_scan_dec;

  localparam int STABLE = 4;

  logic        clk = 1'b0;
  logic        rst, in_en, out_ready;
  logic [7:0]  seg_n;
  logic [2:0]  sel;
  logic        out_valid, out_dp, out_err, out_blank, overrun;
  logic [3:0]  out_digit;
  logic [2:0]  out_idx;
  logic [31:0] digits;
  logic [7:0]  err_mask;

  seg7_scan_dec #(.STABLE_CYC(STABLE)) dut (
    .clk(clk), .rst(rst), .in_en(in_en), .seg_n(seg_n), .sel(sel),
    .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit),
    .out_idx(out_idx), .out_dp(out_dp), .out_err(out_err), .out_blank(out_blank),
    .digits(digits), .err_mask(err_mask), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid_seen = 0;

  logic [6:0] ref_pat [16] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3C, 7'h4F, 7'h47
  };

  // Model: a result appears when the same enabled sample has been seen exactly STABLE times in a row
  bit          m_have;
  logic [10:0] m_prev;
  int          m_run;
  bit          m_valid, m_dp, m_err, m_blank, m_ovr;
  logic [3:0]  m_digit;
  logic [2:0]  m_idx;
  logic [31:0] m_digits;
  logic [7:0]  m_err_mask;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic ref_decode(input logic [7:0] s, output logic [3:0] d, output bit e, output bit b);
    logic [6:0] p;
    p = ~s[7:1];
    d = 4'd0; e = 1'b1; b = 1'b0;
    if (p == 7'h00) begin
      e = 1'b0; b = 1'b1;
    end else begin
      for (int k = 0; k < 16; k++)
        if (ref_pat[k] == p) begin d = 4'(k); e = 1'b0; end
    end
  endtask

  task automatic model_step(input bit r, input bit en, input logic [7:0] s,
                            input logic [2:0] sl, input bit rdy);
    logic [10:0] smp;
    logic [3:0]  d;
    bit          e, b, emit;
    smp = {s, sl};
    if (r) begin
      m_have = 0; m_run = 0; m_valid = 0; m_digit = 0; m_idx = 0; m_dp = 0;
      m_err = 0; m_blank = 0; m_digits = 0; m_err_mask = 0; m_ovr = 0;
      return;
    end
    emit = 0;
    if (!en) begin
      m_have = 0; m_run = 0;
    end else begin
      if (!m_have || smp != m_prev) begin
        m_have = 1; m_prev = smp; m_run = 1;
      end else if (m_run < 1000) begin
        m_run++;
      end
      emit = (m_run == STABLE);
    end
    if (emit) begin
      ref_decode(s, d, e, b);
      if (!e && !b) m_digits[int'(sl)*4 +: 4] = d;
      m_err_mask[sl] = e;
      if (!m_valid || rdy) begin
        m_valid = 1; m_digit = d; m_idx = sl; m_dp = ~s[0]; m_err = e; m_blank = b;
      end else begin
        m_ovr = 1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
  endtask

  task automatic cyc(input bit r, input bit en, input logic [7:0] s,
                     input logic [2:0] sl, input bit rdy);
    rst = r; in_en = en; seg_n = s; sel = sl; out_ready = rdy;
    @(posedge clk);
    #1;
    model_step(r, en, s, sl, rdy);
    if (out_valid) n_valid_seen++;
    check("out_valid", out_valid, m_valid);
    check("out_digit", out_digit, m_digit);
    check("out_idx",   out_idx,   m_idx);
    check("out_dp",    out_dp,    m_dp);
    check("out_err",   out_err,   m_err);
    check("out_blank", out_blank, m_blank);
    check("digits",    digits,    m_digits);
    check("err_mask",  err_mask,  m_err_mask);
    check("overrun",   overrun,   m_ovr);
  endtask

  task automatic hold(input int n, input logic [7:0] s, input logic [2:0] sl, input bit rdy);
    for (int i = 0; i < n; i++) cyc(0, 1, s, sl, rdy);
  endtask

  initial begin
    logic [7:0] s;
    logic [2:0] sl;
    int         len;

    cyc(1, 0, 8'hFF, 3'd0, 1);
    cyc(1, 0, 8'hFF, 3'd0, 1);
    check("rst_valid", out_valid, 0);
    check("rst_digits", digits, 0);
    check("rst_overrun", overrun, 0);

    hold(3, 8'h0D, 3'd2, 1);
    check("stable4_early", out_valid, 0);
    hold(1, 8'h0D, 3'd2, 1);
    check("stable4_valid", out_valid, 1);
    check("stable4_digit", out_digit, 3);
    check("stable4_idx", out_idx, 2);
    check("stable4_store", digits[11:8], 3);

    n_valid_seen = 0;
    hold(3, 8'h0D, 3'd0, 1);
    check("short_run_none", n_valid_seen, 0);
    hold(6, 8'h1F, 3'd0, 1);
    check("seven_once", n_valid_seen, 1);
    check("seven_store", digits, 32'h0000_0307);

    hold(4, 8'h7F, 3'd5, 1);
    check("inv_err", out_err, 1);
    check("inv_mask", err_mask, 8'h20);
    check("inv_digits", digits, 32'h0000_0307);
    hold(4, 8'h9F, 3'd5, 1);
    check("inv_cleared", err_mask, 8'h00);
    check("one_store", digits, 32'h0010_0307);

    hold(4, 8'hFF, 3'd6, 1);
    check("blank_flag", out_blank, 1);
    check("blank_err", out_err, 0);
    check("blank_digits", digits, 32'h0010_0307);
    n_valid_seen = 0;
    hold(20, 8'h24, 3'd7, 1);
    check("held20_once", n_valid_seen, 1);
    check("two_store", digits, 32'h2010_0307);

    hold(4, 8'h0D, 3'd3, 0);
    hold(4, 8'h9F, 3'd4, 0);
    check("ovr_valid", out_valid, 1);
    check("ovr_first_digit", out_digit, 3);
    check("ovr_first_idx", out_idx, 3);
    check("ovr_flag", overrun, 1);
    check("ovr_digits", digits, 32'h2011_3307);

    cyc(1, 1, 8'h0D, 3'd1, 0);
    check("rst_held_valid", out_valid, 0);
    check("rst_held_ovr", overrun, 0);
    check("rst_held_digits", digits, 0);
    hold(2, 8'h0D, 3'd1, 1);
    cyc(1, 1, 8'h0D, 3'd1, 1);
    hold(3, 8'h0D, 3'd1, 1);
    check("restart_early", out_valid, 0);
    hold(1, 8'h0D, 3'd1, 1);
    check("restart_valid", out_valid, 1);
    check("restart_idx", out_idx, 1);

    for (int blk = 0; blk < 120; blk++) begin
      case ($urandom_range(0, 3))
        0:       s = {~ref_pat[$urandom_range(0, 15)], 1'($urandom_range(0, 1))};
        1:       s = {7'h7F, 1'($urandom_range(0, 1))};
        default: s = 8'($urandom_range(0, 255));
      endcase
      sl  = 3'($urandom_range(0, 7));
      len = $urandom_range(1, 7);
      for (int i = 0; i < len; i++)
        cyc($urandom_range(0, 199) == 0, $urandom_range(0, 15) != 0, s, sl,
            $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
